hazard_ctrl_unit: RTL and testbench

//  Pipeline hazard controller on the EX side of the ID/EX pipeline register.
//  - Reads the load info held in ID/EX and the source regs being decoded in ID.
//  - Drives the stall and write-enable controls for PC and IF/ID.
//  - Drives the bubble control for ID/EX and the flush for IF/ID.
//  - Handles load-use stalls (fixed multi-cycle length) and EX-resolved branch/jump redirects.
//  - Keeps saturating event counters for stall and flush activity.

---
 rtl/hazard_ctrl_unit_if.sv | 47 ++++
 rtl/hazard_ctrl_unit.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of the hazard controller's pipeline-side signals.
// master : pipeline side; drives the ID/EX and redirect information and
//          receives the stall/flush controls and the event counters.
// slave  : hazard_ctrl_unit side.
// Signals
//   id_rs1, id_rs2          source registers of the instruction in ID
//   id_use_rs1, id_use_rs2  instruction in ID reads rs1 / rs2
//   idex_memread            MemRead field held in ID/EX (nonzero = load)
//   idex_rd                 destination register held in ID/EX
//   ex_redirect             EX resolved a taken branch/jump this cycle
//   pc_write, ifid_write    PC / IF-ID load enables
//   ifid_flush              IF/ID clears to NOP
//   idex_bubble             ID/EX loads zeroed controls
//   stall_cnt, flush_cnt    saturating event counters
// RF_ADDRESS and CNT_W must match the parameters of the connected unit.
interface hazard_ctrl_unit_if #(
    parameter int RF_ADDRESS = 5,
    parameter int CNT_W      = 16
);
    logic [RF_ADDRESS-1:0] id_rs1;
    logic [RF_ADDRESS-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [2:0]            idex_memread;
    logic [RF_ADDRESS-1:0] idex_rd;
    logic                  ex_redirect;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               idex_memread, idex_rd, ex_redirect,
        input  pc_write, ifid_write, ifid_flush, idex_bubble,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               idex_memread, idex_rd, ex_redirect,
        output pc_write, ifid_write, ifid_flush, idex_bubble,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller sitting on the EX side of the ID/EX register.
// Detects load-use hazards between the load held in ID/EX and the sources of
// the instruction in ID, stalls PC and IF/ID for LOAD_STALL_CYC cycles while
// bubbling ID/EX, and flushes IF/ID + bubbles ID/EX on an EX redirect
// (redirect wins over a hazard and aborts a stall in progress).
// Outputs are Mealy and act in the same cycle as the inputs.
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset; while low the outputs are forced to
//          pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1
//   bus    hazard_ctrl_unit_if.slave (see interface for the signal list)
// Parameters
//   RF_ADDRESS      register-file address width
//   LOAD_STALL_CYC  stall cycles per load-use hazard, legal range 1..15
//   CNT_W           width of the saturating stall/flush counters
module hazard_ctrl_unit #(
    parameter int          RF_ADDRESS     = 5,
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int          CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_ctrl_unit_if.slave  bus
);

    typedef enum logic {
        RUN,
        STALL
    } state_t;

    // The detection cycle is the first stall cycle, so STALL covers the rest.
    localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL_CYC - 1);
    localparam bit         MULTI      = (LOAD_STALL_CYC > 1);

    logic [RF_ADDRESS-1:0] rs1;
    logic [RF_ADDRESS-1:0] rs2;
    logic [RF_ADDRESS-1:0] rd;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       rem;
    logic [3:0]       rem_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic hazard;
    logic stall_inc;
    logic flush_inc;
    logic pc_w;
    logic ifid_w;
    logic ifid_fl;
    logic bubble;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.idex_rd;

    // x0 is never written, so a load targeting it cannot create a hazard.
    assign hazard = (bus.idex_memread != 3'd0) && (rd != '0) &&
                    ((bus.id_use_rs1 && (rs1 == rd)) ||
                     (bus.id_use_rs2 && (rs2 == rd)));

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        ifid_fl   = 1'b0;
        bubble    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        case (state)
            RUN: begin
                if (bus.ex_redirect) begin
                    ifid_fl   = 1'b1;
                    bubble    = 1'b1;
                    flush_inc = 1'b1;
                end else if (hazard) begin
                    pc_w      = 1'b0;
                    ifid_w    = 1'b0;
                    bubble    = 1'b1;
                    stall_inc = 1'b1;
                    if (MULTI) begin
                        state_nxt = STALL;
                        rem_nxt   = STALL_INIT;
                    end
                end
            end
            STALL: begin
                if (bus.ex_redirect) begin
                    ifid_fl   = 1'b1;
                    bubble    = 1'b1;
                    flush_inc = 1'b1;
                    state_nxt = RUN;
                    rem_nxt   = 4'd0;
                end else begin
                    // Hazard is not re-evaluated here: ID/EX already holds a bubble.
                    pc_w      = 1'b0;
                    ifid_w    = 1'b0;
                    bubble    = 1'b1;
                    stall_inc = 1'b1;
                    rem_nxt   = rem - 4'd1;
                    if (rem == 4'd1) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
                rem_nxt   = 4'd0;
            end
        endcase

        // Outputs follow the asynchronous reset immediately.
        if (!rst_n) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            ifid_fl = 1'b1;
            bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= 4'd0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_write    = pc_w;
    assign bus.ifid_write  = ifid_w;
    assign bus.ifid_flush  = ifid_fl;
    assign bus.idex_bubble = bubble;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit. Two instances share one stimulus stream:
// u_dut1 (LOAD_STALL_CYC=1, CNT_W=16) and u_dut3 (LOAD_STALL_CYC=3, CNT_W=4).
// Each is tracked by a behavioural model that counts remaining stall cycles
// and keeps unbounded event totals, clipped to the counter range on compare.
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, redir;
    logic [2:0] memrd;

    hazard_ctrl_unit_if #(.RF_ADDRESS(5), .CNT_W(16)) bus1 ();
    hazard_ctrl_unit_if #(.RF_ADDRESS(5), .CNT_W(4))  bus3 ();

    assign bus1.id_rs1 = rs1;        assign bus3.id_rs1 = rs1;
    assign bus1.id_rs2 = rs2;        assign bus3.id_rs2 = rs2;
    assign bus1.id_use_rs1 = use1;   assign bus3.id_use_rs1 = use1;
    assign bus1.id_use_rs2 = use2;   assign bus3.id_use_rs2 = use2;
    assign bus1.idex_memread = memrd; assign bus3.idex_memread = memrd;
    assign bus1.idex_rd = rd;        assign bus3.idex_rd = rd;
    assign bus1.ex_redirect = redir; assign bus3.ex_redirect = redir;

    hazard_ctrl_unit #(.RF_ADDRESS(5), .LOAD_STALL_CYC(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    hazard_ctrl_unit #(.RF_ADDRESS(5), .LOAD_STALL_CYC(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    int checks = 0;
    int failures = 0;

    // Model state: index 0 -> u_dut1, index 1 -> u_dut3
    int lsc [2] = '{1, 3};
    int cap [2] = '{65535, 15};
    int left [2];
    int n_stall [2];
    int n_flush [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_hazard();
        bit reads_rd;
        if (memrd == 3'd0 || rd == 5'd0) return 1'b0;
        reads_rd = (use1 && rs1 == rd) || (use2 && rs2 == rd);
        return reads_rd;
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_bubble}
    function automatic logic [3:0] ref_out(input int k);
        if (!rst_n)                         return 4'b0011;
        if (redir)                          return 4'b1111;
        if (left[k] > 0 || ref_hazard())    return 4'b0001;
        return 4'b1100;
    endfunction

    function automatic int clip(input int v, input int c);
        return (v > c) ? c : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            left[k] = 0; n_stall[k] = 0; n_flush[k] = 0;
        end
    endtask

    task automatic model_clock();
        bit hz;
        hz = ref_hazard();
        for (int k = 0; k < 2; k++) begin
            if (redir) begin
                n_flush[k]++;
                left[k] = 0;
            end else if (left[k] > 0) begin
                n_stall[k]++;
                left[k]--;
            end else if (hz) begin
                n_stall[k]++;
                left[k] = lsc[k] - 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_out1"}, 32'({bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_bubble}), 32'(ref_out(0)));
        chk({tag, "_out3"}, 32'({bus3.pc_write, bus3.ifid_write, bus3.ifid_flush, bus3.idex_bubble}), 32'(ref_out(1)));
        chk({tag, "_stall1"}, 32'(bus1.stall_cnt), 32'(clip(n_stall[0], cap[0])));
        chk({tag, "_stall3"}, 32'(bus3.stall_cnt), 32'(clip(n_stall[1], cap[1])));
        chk({tag, "_flush1"}, 32'(bus1.flush_cnt), 32'(clip(n_flush[0], cap[0])));
        chk({tag, "_flush3"}, 32'(bus3.flush_cnt), 32'(clip(n_flush[1], cap[1])));
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                         input logic [2:0] mr, input logic [4:0] d, input logic r);
        rs1 = a1; rs2 = a2; use1 = u1; use2 = u2; memrd = mr; rd = d; redir = r;
    endtask

    // Called at posedge+1: check Mealy outputs mid-cycle, then advance the model.
    task automatic cycle(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle(input string tag);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
        cycle(tag);
    endtask

    initial begin
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out1", 32'({bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_bubble}), 32'h3);
        chk("rst_out3", 32'({bus3.pc_write, bus3.ifid_write, bus3.ifid_flush, bus3.idex_bubble}), 32'h3);
        chk("rst_stall1", 32'(bus1.stall_cnt), 32'd0);
        chk("rst_flush3", 32'(bus3.flush_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle("run0");

        // Load-use on rs2
        drive(5'd0, 5'd5, 1'b0, 1'b1, 3'b010, 5'd5, 1'b0);
        @(negedge clk);
        chk("lu_out1", 32'({bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_bubble}), 32'h1);
        @(posedge clk);
        model_clock();
        #1;
        idle("lu_after");
        chk("lu_stall1", 32'(bus1.stall_cnt), 32'd1);
        idle("lu_drain");
        chk("lu_stall3", 32'(bus3.stall_cnt), 32'd3);

        // No hazard: rd = x0, and matching rs1 that is not read
        drive(5'd0, 5'd0, 1'b1, 1'b1, 3'b010, 5'd0, 1'b0);
        cycle("nh_x0");
        drive(5'd7, 5'd3, 1'b0, 1'b1, 3'b001, 5'd7, 1'b0);
        cycle("nh_unused");
        chk("nh_stall1", 32'(bus1.stall_cnt), 32'd1);

        // Redirect has priority over a hazard in RUN
        drive(5'd5, 5'd0, 1'b1, 1'b0, 3'b010, 5'd5, 1'b1);
        @(negedge clk);
        chk("rp_out1", 32'({bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_bubble}), 32'hF);
        chk("rp_out3", 32'({bus3.pc_write, bus3.ifid_write, bus3.ifid_flush, bus3.idex_bubble}), 32'hF);
        @(posedge clk);
        model_clock();
        #1;
        chk("rp_flush1", 32'(bus1.flush_cnt), 32'd1);
        chk("rp_stall1", 32'(bus1.stall_cnt), 32'd1);

        // Asynchronous reset in the middle of a 3-cycle stall
        drive(5'd9, 5'd0, 1'b1, 1'b0, 3'b100, 5'd9, 1'b0);
        cycle("mr_haz");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mr_in_reset");
        chk("mr_stall3", 32'(bus3.stall_cnt), 32'd0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle("mr_run");

        // LOAD_STALL_CYC=3 aborted by a redirect in its 2nd cycle
        drive(5'd4, 5'd0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b0);
        cycle("ab_haz");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1);
        cycle("ab_redir");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("ab_run3", 32'({bus3.pc_write, bus3.ifid_write, bus3.ifid_flush, bus3.idex_bubble}), 32'hC);
        chk("ab_stall3", 32'(bus3.stall_cnt), 32'd1);
        chk("ab_flush3", 32'(bus3.flush_cnt), 32'd1);
        @(posedge clk);
        model_clock();
        #1;

        // Saturation: 20 further stall cycles on the 4-bit counters
        drive(5'd0, 5'd6, 1'b0, 1'b1, 3'b011, 5'd6, 1'b0);
        for (int i = 0; i < 20; i++) cycle("sat");
        @(negedge clk);
        chk("sat_stall3", 32'(bus3.stall_cnt), 32'hF);
        chk("sat_stall1", 32'(bus1.stall_cnt), 32'd21);
        @(posedge clk);
        model_clock();
        #1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                  5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 5) == 0));
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
